// File: rtl/ip_dst_extract.sv
// ip_dst_extract: 2-entry AXI4-Stream register buffer with a side parser that extracts the
// IPv4 destination address, plus packet / IPv4 / single-beat packet counters.
module ip_dst_extract #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXI_DATA_WIDTH   = 32
) (
    input  logic                                AXI_ACLK,
    input  logic                                reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
    input  logic                                S_AXIS_TVALID,
    input  logic                                S_AXIS_TLAST,
    output logic                                S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic [31:0]                         dst_ip,
    output logic                                is_ipv4,
    output logic                                hdr_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       ipv4_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       short_count
);
    localparam int EW = 1 + C_S_AXIS_TUSER_WIDTH + C_S_AXIS_DATA_WIDTH / 8 + C_S_AXIS_DATA_WIDTH;
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] ONE = 1;

    typedef enum logic [1:0] {SOP, HDR2, PAYLOAD} state_t;

    logic [EW-1:0] din, head_q, head_d, tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push, pop;
    state_t        state_q, state_d;
    logic          at_sop, emit_full, emit_short, ipv4_hit;
    logic [15:0]   ethertype_q, ethertype_d, ip_hi_q, ip_hi_d;
    logic [7:0]    verihl_q, verihl_d;
    logic [31:0]   dst_ip_q, dst_ip_d;
    logic          is_ipv4_q, is_ipv4_d, hdr_valid_q, hdr_valid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] pkt_q, pkt_d, ipv4_q, ipv4_d, short_q, short_d;

    assign din           = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    assign S_AXIS_TREADY = cnt_q != 2'd2;
    assign M_AXIS_TVALID = cnt_q != 2'd0;
    assign push          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;
    assign {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TDATA} = head_q;

    // head_q drives M_AXIS directly; tail_q only holds the second beat when full
    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d = (pop && cnt_q == 2'd2) ? tail_q :
                 (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? din : head_q;
        tail_d = (push && !pop && cnt_q == 2'd1) ? din : tail_q;
    end

    always_ff @(posedge AXI_ACLK or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge AXI_ACLK or posedge reset) begin
        if (reset) state_q <= SOP;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (push) begin
            case (state_q)
                SOP:     state_d = S_AXIS_TLAST ? SOP : HDR2;
                HDR2:    state_d = S_AXIS_TLAST ? SOP : PAYLOAD;
                default: state_d = S_AXIS_TLAST ? SOP : PAYLOAD;
            endcase
        end
    end

    always_comb begin
        at_sop      = push && state_q == SOP;
        emit_full   = push && state_q == HDR2;
        emit_short  = at_sop && S_AXIS_TLAST;
        ipv4_hit    = ethertype_q == 16'h0800 && verihl_q == 8'h45;
        ethertype_d = at_sop ? S_AXIS_TDATA[159:144] : ethertype_q;
        verihl_d    = at_sop ? S_AXIS_TDATA[143:136] : verihl_q;
        ip_hi_d     = at_sop ? S_AXIS_TDATA[15:0] : ip_hi_q;
        dst_ip_d    = emit_full ? {ip_hi_q, S_AXIS_TDATA[255:240]} : emit_short ? 32'h0 : dst_ip_q;
        is_ipv4_d   = emit_full ? ipv4_hit : emit_short ? 1'b0 : is_ipv4_q;
        hdr_valid_d = emit_full | emit_short;
        pkt_d       = hdr_valid_d ? pkt_q + ONE : pkt_q;
        ipv4_d      = (emit_full && ipv4_hit) ? ipv4_q + ONE : ipv4_q;
        short_d     = emit_short ? short_q + ONE : short_q;
    end

    always_ff @(posedge AXI_ACLK or posedge reset) begin
        if (reset) begin
            ethertype_q <= '0;
            verihl_q    <= '0;
            ip_hi_q     <= '0;
            dst_ip_q    <= '0;
            is_ipv4_q   <= 1'b0;
            hdr_valid_q <= 1'b0;
            pkt_q       <= '0;
            ipv4_q      <= '0;
            short_q     <= '0;
        end else begin
            ethertype_q <= ethertype_d;
            verihl_q    <= verihl_d;
            ip_hi_q     <= ip_hi_d;
            dst_ip_q    <= dst_ip_d;
            is_ipv4_q   <= is_ipv4_d;
            hdr_valid_q <= hdr_valid_d;
            pkt_q       <= pkt_d;
            ipv4_q      <= ipv4_d;
            short_q     <= short_d;
        end
    end

    assign dst_ip      = dst_ip_q;
    assign is_ipv4     = is_ipv4_q;
    assign hdr_valid   = hdr_valid_q;
    assign pkt_count   = pkt_q;
    assign ipv4_count  = ipv4_q;
    assign short_count = short_q;
endmodule
